// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared types and constants for the echo delay-line sequencer
package echo_pkg;

  // Default FIFO address width; the delay line holds up to 2**AW samples
  localparam int ECHO_AW = 10;

  // Converter offsets used by the surrounding echo datapath
  localparam logic [9:0] ADC_OFFSET = 10'h181;
  localparam logic [9:0] DAC_OFFSET = 10'h200;

  // Sequencer states: clear the FIFO, fill it to the delay length, then stream
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } echo_state_t;

endpackage

// File: rtl/echo_tick_sync.sv
// rtl/echo_tick_sync.sv - synchronise ADC data_valid and emit one tick per rising edge
module echo_tick_sync (
  input  logic sysclk,
  input  logic rst,
  input  logic data_valid,
  output logic tick
);

  logic sync_a;
  logic sync_b;
  logic sync_b_d;

  // Two-flop synchroniser, a delayed copy for edge detection, and a registered rising-edge pulse
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      sync_b_d <= 1'b0;
      tick     <= 1'b0;
    end else begin
      sync_a   <= data_valid;
      sync_b   <= sync_a;
      sync_b_d <= sync_b;
      tick     <= sync_b & ~sync_b_d;
    end
  end

endmodule

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - primes the echo delay FIFO and issues lock-step write/read requests
module echo_delay_ctrl
  import echo_pkg::*;
#(
  parameter int AW            = ECHO_AW,
  parameter int DEFAULT_DELAY = 1000
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [AW-1:0] delay_len,
  input  logic          delay_load,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic          sample_tick,
  output logic          wrreq,
  output logic          rdreq,
  output logic          fifo_sclr,
  output logic          echo_en,
  output logic          priming,
  output logic          overrun
);

  echo_state_t   state;
  logic [AW-1:0] delay_reg;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] fill_nxt;
  logic          tick;

  echo_tick_sync u_tick_sync (
    .sysclk     (sysclk),
    .rst        (rst),
    .data_valid (data_valid),
    .tick       (tick)
  );

  // The synchroniser output is already a register, so it serves directly as the datapath enable
  assign sample_tick = tick;

  // fill_cnt stays below delay_reg while priming, so this increment cannot wrap
  assign fill_nxt = fill_cnt + AW'(1);

  // Sequencer: a delay change or reset always restarts from a cleared FIFO; a load beats a same-cycle tick
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      delay_reg <= AW'(DEFAULT_DELAY);
      fill_cnt  <= '0;
      wrreq     <= 1'b0;
      rdreq     <= 1'b0;
      fifo_sclr <= 1'b1;
      echo_en   <= 1'b0;
      priming   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wrreq     <= 1'b0;
      rdreq     <= 1'b0;
      fifo_sclr <= 1'b0;
      if (delay_load) begin
        delay_reg <= (delay_len == '0) ? AW'(1) : delay_len;
        state     <= ST_CLEAR;
        fifo_sclr <= 1'b1;
        fill_cnt  <= '0;
        echo_en   <= 1'b0;
        priming   <= 1'b0;
      end else begin
        case (state)
          ST_CLEAR: begin
            fill_cnt <= '0;
            echo_en  <= 1'b0;
            priming  <= 1'b1;
            state    <= ST_PRIME;
          end
          ST_PRIME: begin
            if (tick) begin
              if (fifo_full) begin
                overrun <= 1'b1;
              end else begin
                wrreq    <= 1'b1;
                fill_cnt <= fill_nxt;
                if (fill_nxt == delay_reg) begin
                  state   <= ST_RUN;
                  priming <= 1'b0;
                  echo_en <= 1'b1;
                end
              end
            end
          end
          ST_RUN: begin
            if (tick) begin
              if (fifo_full) overrun <= 1'b1;
              else           wrreq   <= 1'b1;
              if (fifo_empty) overrun <= 1'b1;
              else            rdreq   <= 1'b1;
            end
          end
          default: begin
            state     <= ST_CLEAR;
            fifo_sclr <= 1'b1;
            fill_cnt  <= '0;
            echo_en   <= 1'b0;
            priming   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - directed self-checking bench for echo_delay_ctrl
module tb_echo_delay_ctrl;

  localparam int AW = 10;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic [AW-1:0] delay_len = '0;
  logic          delay_load = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_empty = 1'b0;
  logic          sample_tick, wrreq, rdreq, fifo_sclr, echo_en, priming, overrun;

  int total = 0;
  int bad = 0;

  // Values captured around one ADC sample
  int   t_lat;
  logic t_pr, t_en, t_w, t_r, t_en2, t_ovr, t_w2;
  int   tick_cnt, tick_pos;

  echo_delay_ctrl #(.AW(AW), .DEFAULT_DELAY(4)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .data_valid  (data_valid),
    .delay_len   (delay_len),
    .delay_load  (delay_load),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .sample_tick (sample_tick),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .fifo_sclr   (fifo_sclr),
    .echo_en     (echo_en),
    .priming     (priming),
    .overrun     (overrun)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One ADC sample: raise data_valid, wait for the tick, capture request outputs, then drop it
  task automatic do_sample();
    data_valid = 1'b1;
    t_lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge sysclk);
      if (sample_tick) begin
        t_lat = i;
        break;
      end
    end
    t_pr = priming;
    t_en = echo_en;
    @(negedge sysclk);
    t_w   = wrreq;
    t_r   = rdreq;
    t_en2 = echo_en;
    t_ovr = overrun;
    @(negedge sysclk);
    t_w2 = wrreq | rdreq;
    data_valid = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic sample_expect(input string tag, input logic w, input logic r);
    do_sample();
    check_eq({tag, "_lat"}, t_lat, 3);
    check_eq({tag, "_wr"}, t_w, w);
    check_eq({tag, "_rd"}, t_r, r);
    check_eq({tag, "_one"}, t_w2, 1'b0);
  endtask

  task automatic pulse_load(input logic [AW-1:0] len);
    delay_len  = len;
    delay_load = 1'b1;
    @(negedge sysclk);
    delay_load = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    check_eq("rst_sclr", fifo_sclr, 1'b1);
    check_eq("rst_outs", {sample_tick, wrreq, rdreq, echo_en, priming, overrun}, 6'b0);
    rst = 1'b0;
    @(negedge sysclk);
    check_eq("exit_sclr", fifo_sclr, 1'b0);
    check_eq("exit_prime", priming, 1'b1);

    // Prime four samples, then stream
    for (int k = 1; k <= 4; k++) begin
      sample_expect("t1_prime", 1'b1, 1'b0);
      check_eq("t1_pr", t_pr, 1'b1);
      check_eq("t1_en", t_en, 1'b0);
    end
    check_eq("t1_en_run", t_en2, 1'b1);
    check_eq("t1_pr_run", priming, 1'b0);
    for (int k = 5; k <= 6; k++) begin
      sample_expect("t1_run", 1'b1, 1'b1);
      check_eq("t1_en5", t_en, 1'b1);
    end

    // Long data_valid level produces one tick, 3 cycles in
    data_valid = 1'b1;
    tick_cnt = 0;
    tick_pos = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge sysclk);
      if (sample_tick) begin
        tick_cnt++;
        if (tick_pos == 0) tick_pos = i;
      end
    end
    data_valid = 1'b0;
    repeat (4) @(negedge sysclk);
    check_eq("t2_ticks", tick_cnt, 1);
    check_eq("t2_pos", tick_pos, 3);

    // Re-prime to delay 2 from RUN
    pulse_load(10'd2);
    check_eq("t3_sclr", fifo_sclr, 1'b1);
    check_eq("t3_en", echo_en, 1'b0);
    @(negedge sysclk);
    check_eq("t3_sclr_off", fifo_sclr, 1'b0);
    check_eq("t3_pr", priming, 1'b1);
    sample_expect("t3_p1", 1'b1, 1'b0);
    sample_expect("t3_p2", 1'b1, 1'b0);
    check_eq("t3_en_run", t_en2, 1'b1);
    sample_expect("t3_run", 1'b1, 1'b1);

    // Load coinciding with a tick drops that tick
    data_valid = 1'b1;
    for (int i = 0; i < 10 && !sample_tick; i++) @(negedge sysclk);
    check_eq("t4_tick", sample_tick, 1'b1);
    pulse_load(10'd3);
    check_eq("t4_wr", wrreq, 1'b0);
    check_eq("t4_rd", rdreq, 1'b0);
    check_eq("t4_clear", fifo_sclr, 1'b1);
    check_eq("t4_en", echo_en, 1'b0);
    data_valid = 1'b0;
    repeat (4) @(negedge sysclk);

    // Full FIFO during priming suppresses the write and sets sticky overrun
    fifo_full = 1'b1;
    sample_expect("t5_full", 1'b0, 1'b0);
    check_eq("t5_ovr", t_ovr, 1'b1);
    fifo_full = 1'b0;
    for (int k = 1; k <= 3; k++) sample_expect("t5_prime", 1'b1, 1'b0);
    sample_expect("t5_run", 1'b1, 1'b1);
    check_eq("t5_ovr_stick", t_ovr, 1'b1);

    // Reset part-way through priming restarts from zero with the default delay
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    check_eq("t6_ovr_clr", overrun, 1'b0);
    for (int k = 1; k <= 3; k++) sample_expect("t6_pre", 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge sysclk);
    check_eq("t6_rst_sclr", fifo_sclr, 1'b1);
    check_eq("t6_rst_en", {echo_en, priming}, 2'b00);
    rst = 1'b0;
    @(negedge sysclk);
    check_eq("t6_pr", priming, 1'b1);
    for (int k = 1; k <= 4; k++) sample_expect("t6_prime", 1'b1, 1'b0);
    check_eq("t6_en_run", t_en2, 1'b1);
    sample_expect("t6_run", 1'b1, 1'b1);

    // Zero delay clamps to a single primed sample
    pulse_load(10'd0);
    @(negedge sysclk);
    sample_expect("t6_z1", 1'b1, 1'b0);
    check_eq("t6_z_en", t_en2, 1'b1);
    sample_expect("t6_z2", 1'b1, 1'b1);
    check_eq("t6_z_ovr", t_ovr, 1'b0);

    // Empty FIFO in RUN suppresses only the read and sets overrun
    fifo_empty = 1'b1;
    sample_expect("empty", 1'b1, 1'b0);
    check_eq("empty_ovr", t_ovr, 1'b1);
    fifo_empty = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
